// File: rtl/bin_to_bcd_digits.sv
// bin_to_bcd_digits
//   Sequential binary-to-BCD converter (shift-add-3 / double dabble) that feeds
//   the four 5-bit digit inputs of the seven-segment hex display driver.
//   One unsigned value is accepted per in_valid/in_ready handshake. The result
//   appears exactly 15 clocks after the accept edge, with a one-cycle done pulse.
//   Values above MAX_VAL show "   E" and raise ovf.
//
// Ports
//   clk       system clock
//   rst_n     asynchronous, active-low reset
//   in_data   unsigned binary value to convert (IN_W bits)
//   in_valid  in_data is valid
//   in_ready  idle and able to accept (combinational from state)
//   num0      thousands digit code (leftmost)
//   num1      hundreds digit code
//   num2      tens digit code
//   num3      units digit code (rightmost)
//   done      one-cycle pulse: num0..num3 were just updated
//   ovf       last accepted value exceeded MAX_VAL
//
// Build option
//   LEADING_ZERO_BLANK_EN : blank leading zeros on num0..num2 (num3 always shown)
module bin_to_bcd_digits #(
  parameter int unsigned IN_W       = 14,
  parameter int unsigned MAX_VAL    = 9999,
  parameter int unsigned BLANK_CODE = 16,
  parameter int unsigned ERR_CODE   = 14
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [4:0]      num0,
  output logic [4:0]      num1,
  output logic [4:0]      num2,
  output logic [4:0]      num3,
  output logic            done,
  output logic            ovf
);

  localparam int unsigned BCD_W = 16;
  localparam int unsigned SR_W  = BCD_W + IN_W;

  localparam logic [IN_W-1:0] MAX_V    = IN_W'(MAX_VAL);
  localparam logic [4:0]      BLANK    = 5'(BLANK_CODE);
  localparam logic [4:0]      ERR      = 5'(ERR_CODE);
  localparam logic [3:0]      LAST_CNT = 4'(IN_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_FORMAT
  } state_t;

  state_t          state, state_next;
  logic [SR_W-1:0] sr;
  logic [SR_W-1:0] sr_adj;
  logic [3:0]      cnt;
  logic            ovf_pend;
  logic [4:0]      fmt0, fmt1, fmt2, fmt3;
  logic            accept;

  assign in_ready = (state == S_IDLE);
  assign accept   = in_valid && in_ready;

  // Add 3 to every BCD nibble >= 5 ahead of the shift.
  always_comb begin
    sr_adj = sr;
    for (int unsigned i = 0; i < 4; i++) begin
      if (sr[IN_W + 4*i +: 4] >= 4'd5)
        sr_adj[IN_W + 4*i +: 4] = sr[IN_W + 4*i +: 4] + 4'd3;
    end
  end

  // Final digit codes computed from the completed BCD field.
  always_comb begin
    fmt0 = {1'b0, sr[SR_W-1   -: 4]};
    fmt1 = {1'b0, sr[SR_W-5   -: 4]};
    fmt2 = {1'b0, sr[SR_W-9   -: 4]};
    fmt3 = {1'b0, sr[SR_W-13  -: 4]};
    if (ovf_pend) begin
      fmt0 = BLANK;
      fmt1 = BLANK;
      fmt2 = BLANK;
      fmt3 = ERR;
    end else begin
`ifdef LEADING_ZERO_BLANK_EN
      // Blank left-to-right until the first nonzero digit; units always shown.
      if (fmt0 == 5'd0) begin
        fmt0 = BLANK;
        if (fmt1 == 5'd0) begin
          fmt1 = BLANK;
          if (fmt2 == 5'd0)
            fmt2 = BLANK;
        end
      end
`endif
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (accept) state_next = S_SHIFT;
      S_SHIFT:  if (cnt == LAST_CNT) state_next = S_FORMAT;
      S_FORMAT: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr       <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      num0     <= BLANK;
      num1     <= BLANK;
      num2     <= BLANK;
      num3     <= BLANK;
      done     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            sr       <= {{BCD_W{1'b0}}, in_data};
            ovf_pend <= (in_data > MAX_V);
            cnt      <= '0;
          end
        end
        S_SHIFT: begin
          sr  <= sr_adj << 1;
          cnt <= cnt + 4'd1;
        end
        S_FORMAT: begin
          num0 <= fmt0;
          num1 <= fmt1;
          num2 <= fmt2;
          num3 <= fmt3;
          ovf  <= ovf_pend;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_digits.sv
// Testbench for bin_to_bcd_digits: directed cases plus random values checked
// against an arithmetic (divide/modulo) reference model.
module tb_bin_to_bcd_digits;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  num0, num1, num2, num3;
  logic        done;
  logic        ovf;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int expected_dones = 0;
  logic [4:0] prev0 = 5'd16, prev1 = 5'd16, prev2 = 5'd16, prev3 = 5'd16;

  bin_to_bcd_digits #(
    .IN_W(14), .MAX_VAL(9999), .BLANK_CODE(16), .ERR_CODE(14)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .num0(num0), .num1(num1), .num2(num2), .num3(num3),
    .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input int v, output logic [4:0] e0, output logic [4:0] e1,
                                output logic [4:0] e2, output logic [4:0] e3, output logic eo);
    if (v > 9999) begin
      e0 = 5'd16; e1 = 5'd16; e2 = 5'd16; e3 = 5'd14; eo = 1'b1;
    end else begin
      e0 = 5'(v / 1000);
      e1 = 5'((v / 100) % 10);
      e2 = 5'((v / 10) % 10);
      e3 = 5'(v % 10);
      eo = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if (v < 1000) e0 = 5'd16;
      if (v < 100)  e1 = 5'd16;
      if (v < 10)   e2 = 5'd16;
`endif
    end
  endfunction

  // Wait (bounded) for in_ready at a negedge, then present v for one accept edge.
  task automatic send(input int v);
    int t = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && t < 40) begin @(negedge clk); t++; end
    if (in_ready !== 1'b1) check("ready_timeout", 0, 1);
    in_data  = 14'(v);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    expected_dones++;
  endtask

  // Called #1 after an accept edge: count edges to done, check busy behaviour and result.
  task automatic wait_result(input int v, input string tag);
    logic [4:0] e0, e1, e2, e3;
    logic eo;
    int lat = 0;
    bit busy_ok = 1'b1;
    bit hold_ok = 1'b1;
    while (done !== 1'b1 && lat < 20) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      if (num0 !== prev0 || num1 !== prev1 || num2 !== prev2 || num3 !== prev3) hold_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    model(v, e0, e1, e2, e3, eo);
    check({tag, "_latency"}, lat, 15);
    check({tag, "_busy_ready"}, int'(busy_ok), 1);
    check({tag, "_hold"}, int'(hold_ok), 1);
    check({tag, "_num0"}, int'(num0), int'(e0));
    check({tag, "_num1"}, int'(num1), int'(e1));
    check({tag, "_num2"}, int'(num2), int'(e2));
    check({tag, "_num3"}, int'(num3), int'(e3));
    check({tag, "_ovf"}, int'(ovf), int'(eo));
    check({tag, "_ready_on_done"}, int'(in_ready), 1);
    prev0 = e0; prev1 = e1; prev2 = e2; prev3 = e3;
  endtask

  task automatic convert(input int v, input string tag);
    send(v);
    wait_result(v, tag);
  endtask

  initial begin
    int dc_before;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_num0", int'(num0), 16);
    check("rst_num1", int'(num1), 16);
    check("rst_num2", int'(num2), 16);
    check("rst_num3", int'(num3), 16);
    check("rst_done", int'(done), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_ready", int'(in_ready), 1);

    convert(1234, "v1234");
    convert(42, "v42");
    convert(0, "v0");
    convert(9999, "v9999");
    convert(10000, "v10000");
    convert(16383, "v16383");
    convert(7, "v7");
    convert(305, "v305");

    // in_valid held high while busy: only the first value converts, the
    // second is taken on the done cycle.
    @(negedge clk);
    in_data = 14'd5678;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_data = 14'd1111;
    expected_dones++;
    wait_result(5678, "hold5678");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    expected_dones++;
    wait_result(1111, "next1111");

    // Reset at clock 7 of a conversion aborts it.
    send(4321);
    expected_dones--;
    repeat (6) @(posedge clk);
    #2;
    dc_before = done_cnt;
    rst_n = 1'b0;
    #1;
    check("abort_num0", int'(num0), 16);
    check("abort_num1", int'(num1), 16);
    check("abort_num2", int'(num2), 16);
    check("abort_num3", int'(num3), 16);
    check("abort_ovf", int'(ovf), 0);
    check("abort_ready", int'(in_ready), 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - dc_before, 0);
    prev0 = 5'd16; prev1 = 5'd16; prev2 = 5'd16; prev3 = 5'd16;

    convert(9998, "after_rst");
    convert(10001, "ovf_again");
    convert(1, "ovf_clear");

    for (int i = 0; i < 300; i++) begin
      int v;
      v = (i % 3 == 0) ? int'($urandom_range(0, 16383)) : int'($urandom_range(0, 9999));
      convert(v, "rand");
    end

    repeat (3) @(posedge clk);
    check("done_count", done_cnt, expected_dones);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
